// File: rtl/spi_pin_ctrl.sv
// SPI-slave (mode 0) pin controller: synchronises SCLK/CS/MOSI into CLK, assembles
// MSB-first command bytes and applies toggle/set/clear/bulk operations to the pin bank.
module spi_pin_ctrl #(
  parameter int unsigned NUM_PINS    = 64,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                SCLK,
  input  logic                CS,
  input  logic                MOSI,
  input  logic                err_clr,
  output logic [NUM_PINS-1:0] pins,
  output logic                cmd_valid,
  output logic [CNT_W-1:0]    cmd_cnt,
  output logic                err
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_BW = 3;
  localparam int unsigned IDX_W  = 6;

  typedef enum logic [1:0] {
    OP_TOGGLE = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_BULK   = 2'b11
  } op_e;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_prev;
  logic                   cs_prev;
  logic [BYTE_W-1:0]      shift_reg;
  logic [CNT_BW-1:0]      bit_cnt;
  logic                   byte_rdy;

  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   bit_stb;
  logic                   cs_rise;

  op_e                    op;
  logic [IDX_W-1:0]       idx;
  logic                   idx_ok;
  logic [NUM_PINS-1:0]    idx_mask;
  logic [NUM_PINS-1:0]    pins_nxt;
  logic                   cmd_ok;
  logic                   err_set;

  // Input synchronisers, reset to the idle bus state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign bit_stb = sclk_s & ~sclk_prev & ~cs_s;
  assign cs_rise = cs_s & ~cs_prev;

  // Byte assembly; a completing bit takes priority over a frame abort.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      byte_rdy  <= 1'b0;
    end else begin
      byte_rdy <= 1'b0;
      if (bit_stb) begin
        shift_reg <= {shift_reg[BYTE_W-2:0], mosi_s};
        bit_cnt   <= bit_cnt + CNT_BW'(1);
        byte_rdy  <= (bit_cnt == '1);
      end else if (cs_rise) begin
        bit_cnt <= '0;
      end
    end
  end

  // Command decode; shift_reg is stable while byte_rdy is high because the
  // next qualified SCLK edge is several CLK cycles away.
  always_comb begin
    op       = op_e'(shift_reg[7:6]);
    idx      = shift_reg[IDX_W-1:0];
    idx_ok   = (7'(idx) < 7'(NUM_PINS));
    idx_mask = NUM_PINS'(1) << idx;
    pins_nxt = pins;
    cmd_ok   = idx_ok;
    case (op)
      OP_TOGGLE: pins_nxt = pins ^ idx_mask;
      OP_SET:    pins_nxt = pins | idx_mask;
      OP_CLEAR:  pins_nxt = pins & ~idx_mask;
      OP_BULK: begin
        cmd_ok = 1'b1;
        if (idx == IDX_W'(0)) begin
          pins_nxt = '0;
        end else if (idx == IDX_W'(1)) begin
          pins_nxt = '1;
        end else begin
          cmd_ok = 1'b0;
        end
      end
      default: cmd_ok = 1'b0;
    endcase
  end

  assign err_set = byte_rdy & ~cmd_ok;

  // Execute stage; a new error wins over a simultaneous err_clr.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pins      <= '0;
      cmd_valid <= 1'b0;
      cmd_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      cmd_valid <= byte_rdy;
      err       <= err_set | (err & ~err_clr);
      if (byte_rdy && cmd_ok) begin
        pins    <= pins_nxt;
        cmd_cnt <= cmd_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spi_pin_ctrl.sv
// Directed bench for spi_pin_ctrl: a 64-pin instance and an 8-pin instance share
// SCLK/MOSI but have separate chip selects.
module tb_spi_pin_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        cs64 = 1'b1;
  logic        cs8 = 1'b1;
  logic        err_clr = 1'b0;

  logic [63:0] pins64;
  logic        valid64;
  logic [15:0] cnt64;
  logic        err64;
  logic [7:0]  pins8;
  logic        valid8;
  logic [15:0] cnt8;
  logic        err8;

  int checks = 0;
  int errors = 0;
  int vcnt64 = 0;
  int vbase  = 0;

  spi_pin_ctrl #(.NUM_PINS(64), .SYNC_STAGES(2), .CNT_W(16)) dut64 (
    .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .CS(cs64), .MOSI(MOSI), .err_clr(err_clr),
    .pins(pins64), .cmd_valid(valid64), .cmd_cnt(cnt64), .err(err64)
  );

  spi_pin_ctrl #(.NUM_PINS(8), .SYNC_STAGES(2), .CNT_W(16)) dut8 (
    .CLK(CLK), .RST_N(RST_N), .SCLK(SCLK), .CS(cs8), .MOSI(MOSI), .err_clr(err_clr),
    .pins(pins8), .cmd_valid(valid8), .cmd_cnt(cnt8), .err(err8)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (valid64 === 1'b1) vcnt64 <= vcnt64 + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      MOSI = b[7-i];
      #40 SCLK = 1'b1;
      #40 SCLK = 1'b0;
    end
    #60;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    #20 RST_N = 1'b1;
    #20 vbase = vcnt64;
  endtask

  initial begin
    // Reset values
    #1 RST_N = 1'b0;
    #19;
    chk("rst_pins", pins64, 64'h0);
    chk("rst_valid", 64'(valid64), 64'h0);
    chk("rst_cnt", 64'(cnt64), 64'h0);
    chk("rst_err", 64'(err64), 64'h0);
    RST_N = 1'b1;
    #20 vbase = vcnt64;

    // Toggle sequence in one frame
    cs64 = 1'b0; #100;
    send_byte(8'h00); chk("tog0_on", pins64, 64'h1);
    send_byte(8'h00); chk("tog0_off", pins64, 64'h0);
    send_byte(8'h03); chk("tog3_on", pins64, 64'h8);
    send_byte(8'h3F); chk("tog63_on", pins64, 64'h8000_0000_0000_0008);
    send_byte(8'h3F); chk("tog63_off", pins64, 64'h0000_0000_0000_0008);
    chk("tog_cnt", 64'(cnt64), 64'd5);
    chk("tog_pulses", 64'(vcnt64 - vbase), 64'd5);
    cs64 = 1'b1; #100;

    // Set / clear
    do_reset();
    cs64 = 1'b0; #100;
    send_byte(8'h45); chk("set5", pins64, 64'h20);
    send_byte(8'h45); chk("set5_again", pins64, 64'h20);
    send_byte(8'h85); chk("clr5", pins64, 64'h0);
    chk("setclr_err", 64'(err64), 64'h0);
    chk("setclr_cnt", 64'(cnt64), 64'd3);
    cs64 = 1'b1; #100;

    // Bulk ops and reserved error
    do_reset();
    cs64 = 1'b0; #100;
    send_byte(8'hC1); chk("bulk_set", pins64, 64'hFFFF_FFFF_FFFF_FFFF);
    send_byte(8'hC0); chk("bulk_clr", pins64, 64'h0);
    send_byte(8'hC2);
    chk("rsv_err", 64'(err64), 64'h1);
    chk("rsv_pins", pins64, 64'h0);
    chk("rsv_cnt", 64'(cnt64), 64'd2);
    chk("rsv_pulses", 64'(vcnt64 - vbase), 64'd3);
    cs64 = 1'b1; #100;
    err_clr = 1'b1; #10 err_clr = 1'b0; #20;
    chk("err_clr", 64'(err64), 64'h0);

    // 8-pin instance: out-of-range index; SCLK activity above left it idle
    chk("p8_idle", 64'(pins8), 64'h0);
    cs8 = 1'b0; #100;
    send_byte(8'h4A);
    chk("p8_oor_err", 64'(err8), 64'h1);
    chk("p8_oor_pins", 64'(pins8), 64'h0);
    send_byte(8'h47);
    chk("p8_set7", 64'(pins8), 64'h80);
    chk("p8_cnt", 64'(cnt8), 64'd1);
    cs8 = 1'b1; #100;

    // Frame abort discards a partial byte
    do_reset();
    cs64 = 1'b0; #100;
    send_bits(8'h41, 5);
    cs64 = 1'b1; #100;
    cs64 = 1'b0; #100;
    send_byte(8'h42);
    chk("abort_pins", pins64, 64'h4);
    chk("abort_cnt", 64'(cnt64), 64'd1);
    cs64 = 1'b1; #100;

    // Asynchronous reset mid-byte
    do_reset();
    cs64 = 1'b0; #100;
    send_byte(8'hC1);
    chk("pre_arst", pins64, 64'hFFFF_FFFF_FFFF_FFFF);
    send_bits(8'hFF, 3);
    #3 RST_N = 1'b0;
    #1 chk("arst_pins", pins64, 64'h0);
    #16 RST_N = 1'b1;
    #100;
    send_byte(8'h01);
    chk("post_arst", pins64, 64'h2);
    chk("post_arst_cnt", 64'(cnt64), 64'd1);
    cs64 = 1'b1; #100;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
